mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 25 ++
 rtl/mem_arbiter_if.sv | 52 +++++
 rtl/mem_arbiter_word_counter.sv | 53 +++++
 rtl/mem_arbiter.sv | 112 +++++++++++
 tb/tb_mem_arbiter.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared cache package: arbiter state encodings, fill geometry and the
// grant-history type used by the cache fill FSMs and the memory arbiter.
package mem_arbiter_pkg;

  // 16-bit words returned per cache-block fill.
  localparam int unsigned WORDS_PER_BLOCK = 8;

  // Width of the per-fill word counter.
  localparam int unsigned CNT_W = 3;

  // Who owns the memory port.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IFILL  = 2'd1,
    ST_DFILL  = 2'd2,
    ST_DWRITE = 2'd3
  } arb_state_e;

  // Which cache was granted the most recent fill; used to break ties.
  typedef enum logic {
    LAST_I = 1'b0,
    LAST_D = 1'b1
  } last_grant_e;

endpackage : mem_arbiter_pkg

// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side bus of the memory arbiter.
// master: the arbiter's view. slave: the caches plus the memory model.
interface mem_arbiter_if;

  // I-cache fill port
  logic        icache_mem_req;
  logic [15:0] icache_mem_addr;
  logic        icache_grant;
  logic        icache_data_valid;

  // D-cache fill port
  logic        dcache_mem_req;
  logic [15:0] dcache_mem_addr;
  logic        dcache_grant;
  logic        dcache_data_valid;

  // D-cache write-through port
  logic        dcache_wr_req;
  logic [15:0] dcache_wr_addr;
  logic [15:0] dcache_wr_data;
  logic        dcache_wr_ack;

  // Memory port
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_data_valid;

  modport master (
    input  icache_mem_req, icache_mem_addr,
    input  dcache_mem_req, dcache_mem_addr,
    input  dcache_wr_req, dcache_wr_addr, dcache_wr_data,
    input  mem_data_valid,
    output mem_enable, mem_wr, mem_addr, mem_wdata,
    output icache_grant, dcache_grant,
    output icache_data_valid, dcache_data_valid,
    output dcache_wr_ack
  );

  modport slave (
    output icache_mem_req, icache_mem_addr,
    output dcache_mem_req, dcache_mem_addr,
    output dcache_wr_req, dcache_wr_addr, dcache_wr_data,
    output mem_data_valid,
    input  mem_enable, mem_wr, mem_addr, mem_wdata,
    input  icache_grant, dcache_grant,
    input  icache_data_valid, dcache_data_valid,
    input  dcache_wr_ack
  );

endinterface : mem_arbiter_if

// File: rtl/mem_arbiter_word_counter.sv
// Basic D flip-flop cell with synchronous clear, and the fill word counter
// built from it. The counter wraps from WRAP back to 0.

module dff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  // Register with synchronous clear.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (clr_i) q_o <= '0;
    else       q_o <= d_i;
  end

endmodule : dff

module word_counter #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned WRAP  = 7
) (
  input  logic clk,
  input  logic clr_i,
  input  logic inc_i,
  output logic last_o
);

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  assign last_o = (count_q == WIDTH'(WRAP));

  // Next count: hold, increment, or wrap to 0 after the last word.
  // NOTE: count_d gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    count_d = count_q;
    if (inc_i) count_d = last_o ? '0 : count_q + 1'b1;
  end

  dff #(.WIDTH(WIDTH)) u_count (
    .clk   (clk),
    .clr_i (clr_i),
    .d_i   (count_d),
    .q_o   (count_q)
  );

endmodule : word_counter

// File: rtl/mem_arbiter.sv
// Memory arbiter: shares one memory port between the I-cache fill FSM, the
// D-cache fill FSM and D-cache write-through. Writes win in IDLE, fill ties
// alternate, and a fill ends only when the word counter sees the last word.
module mem_arbiter #(
  parameter int unsigned WORDS_PER_BLOCK = mem_arbiter_pkg::WORDS_PER_BLOCK
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus
);

  import mem_arbiter_pkg::*;

  arb_state_e  state_q;
  last_grant_e last_grant_q;
  logic        icache_grant_q;
  logic        dcache_grant_q;

  logic in_fill;
  logic word_valid;
  logic last_word;
  logic fill_done;

  // Data beats only count while a fill owns the port; strays are dropped.
  assign in_fill    = (state_q == ST_IFILL) || (state_q == ST_DFILL);
  assign word_valid = in_fill && bus.mem_data_valid;
  assign fill_done  = word_valid && last_word;

  word_counter #(
    .WIDTH (CNT_W),
    .WRAP  (WORDS_PER_BLOCK - 1)
  ) u_word_counter (
    .clk    (clk),
    .clr_i  (~rst),
    .inc_i  (word_valid),
    .last_o (last_word)
  );

  // Arbitration FSM with registered grants and tie-break history.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      last_grant_q   <= LAST_I;
      icache_grant_q <= 1'b0;
      dcache_grant_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.dcache_wr_req) begin
            state_q <= ST_DWRITE;
          end else if (bus.dcache_mem_req &&
                       (!bus.icache_mem_req || last_grant_q == LAST_I)) begin
            state_q        <= ST_DFILL;
            dcache_grant_q <= 1'b1;
          end else if (bus.icache_mem_req) begin
            state_q        <= ST_IFILL;
            icache_grant_q <= 1'b1;
          end
        end
        ST_IFILL: begin
          if (fill_done) begin
            state_q        <= ST_IDLE;
            icache_grant_q <= 1'b0;
            last_grant_q   <= LAST_I;
          end
        end
        ST_DFILL: begin
          if (fill_done) begin
            state_q        <= ST_IDLE;
            dcache_grant_q <= 1'b0;
            last_grant_q   <= LAST_D;
          end
        end
        ST_DWRITE: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.icache_grant      = icache_grant_q;
  assign bus.dcache_grant      = dcache_grant_q;
  assign bus.icache_data_valid = (state_q == ST_IFILL) && bus.mem_data_valid;
  assign bus.dcache_data_valid = (state_q == ST_DFILL) && bus.mem_data_valid;

  // Memory-port mux: the owner's request passes straight through.
  always_comb begin
    bus.mem_enable    = 1'b0;
    bus.mem_wr        = 1'b0;
    bus.mem_addr      = '0;
    bus.mem_wdata     = '0;
    bus.dcache_wr_ack = 1'b0;
    case (state_q)
      ST_IFILL: begin
        bus.mem_enable = bus.icache_mem_req;
        bus.mem_addr   = bus.icache_mem_addr;
      end
      ST_DFILL: begin
        bus.mem_enable = bus.dcache_mem_req;
        bus.mem_addr   = bus.dcache_mem_addr;
      end
      ST_DWRITE: begin
        bus.mem_enable    = 1'b1;
        bus.mem_wr        = 1'b1;
        bus.mem_addr      = bus.dcache_wr_addr;
        bus.mem_wdata     = bus.dcache_wr_data;
        bus.dcache_wr_ack = 1'b1;
      end
      default: ;
    endcase
  end

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random traffic, all
// checked every cycle against a transaction-level model of port ownership.
module tb_mem_arbiter;

  localparam int WPB = 8;

  // Port owner as seen by the model.
  localparam int OWN_NONE = 0;
  localparam int OWN_I    = 1;
  localparam int OWN_D    = 2;
  localparam int OWN_W    = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter_if bus_if ();

  mem_arbiter #(.WORDS_PER_BLOCK(WPB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.master)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state.
  int owner      = OWN_NONE;
  int words_left = 0;
  bit tie_to_d   = 1'b1;

  // Observed-event tallies for the directed scenarios.
  int          idv_pulses  = 0;
  int          ddv_pulses  = 0;
  int          ack_count   = 0;
  logic [15:0] ack_addr    = '0;
  logic [15:0] ack_data    = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every output against the model's view of the current cycle.
  task automatic check_outputs();
    logic        exp_en  = 1'b0;
    logic        exp_wr  = 1'b0;
    logic [15:0] exp_adr = '0;
    logic        exp_ig  = 1'b0;
    logic        exp_dg  = 1'b0;
    logic        exp_idv = 1'b0;
    logic        exp_ddv = 1'b0;
    logic        exp_ack = 1'b0;
    case (owner)
      OWN_I: begin
        exp_en  = bus_if.icache_mem_req;
        exp_adr = bus_if.icache_mem_addr;
        exp_ig  = 1'b1;
        exp_idv = bus_if.mem_data_valid;
      end
      OWN_D: begin
        exp_en  = bus_if.dcache_mem_req;
        exp_adr = bus_if.dcache_mem_addr;
        exp_dg  = 1'b1;
        exp_ddv = bus_if.mem_data_valid;
      end
      OWN_W: begin
        exp_en  = 1'b1;
        exp_wr  = 1'b1;
        exp_adr = bus_if.dcache_wr_addr;
        exp_ack = 1'b1;
      end
      default: ;
    endcase
    check("mem_enable", 32'(bus_if.mem_enable), 32'(exp_en));
    check("mem_wr", 32'(bus_if.mem_wr), 32'(exp_wr));
    check("mem_addr", 32'(bus_if.mem_addr), 32'(exp_adr));
    check("icache_grant", 32'(bus_if.icache_grant), 32'(exp_ig));
    check("dcache_grant", 32'(bus_if.dcache_grant), 32'(exp_dg));
    check("icache_data_valid", 32'(bus_if.icache_data_valid), 32'(exp_idv));
    check("dcache_data_valid", 32'(bus_if.dcache_data_valid), 32'(exp_ddv));
    check("dcache_wr_ack", 32'(bus_if.dcache_wr_ack), 32'(exp_ack));
    if (owner == OWN_W)
      check("mem_wdata", 32'(bus_if.mem_wdata), 32'(bus_if.dcache_wr_data));
    if (bus_if.icache_data_valid) idv_pulses++;
    if (bus_if.dcache_data_valid) ddv_pulses++;
    if (bus_if.dcache_wr_ack) begin
      ack_count++;
      ack_addr = bus_if.mem_addr;
      ack_data = bus_if.mem_wdata;
    end
  endtask

  // Advance the model by one clock using the inputs sampled at the edge.
  task automatic model_update();
    if (!rst) begin
      owner      = OWN_NONE;
      words_left = 0;
      tie_to_d   = 1'b1;
    end else begin
      case (owner)
        OWN_NONE: begin
          if (bus_if.dcache_wr_req)
            owner = OWN_W;
          else if (bus_if.icache_mem_req && bus_if.dcache_mem_req)
            owner = tie_to_d ? OWN_D : OWN_I;
          else if (bus_if.dcache_mem_req)
            owner = OWN_D;
          else if (bus_if.icache_mem_req)
            owner = OWN_I;
          if (owner == OWN_I || owner == OWN_D) words_left = WPB;
        end
        OWN_I, OWN_D: begin
          if (bus_if.mem_data_valid) begin
            words_left--;
            if (words_left == 0) begin
              tie_to_d = (owner == OWN_I);
              owner    = OWN_NONE;
            end
          end
        end
        default: owner = OWN_NONE;
      endcase
    end
  endtask

  // One cycle: inputs already applied just after the falling edge.
  task automatic step();
    #1;
    check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  // Apply one cycle of stimulus; write bus is kept stable while requested.
  task automatic drive(input bit r, input bit ireq, input bit dreq,
                       input bit wreq, input bit dv);
    rst                    = r;
    bus_if.icache_mem_req  = ireq;
    bus_if.icache_mem_addr = 16'($urandom);
    bus_if.dcache_mem_req  = dreq;
    bus_if.dcache_mem_addr = 16'($urandom);
    if (!wreq) begin
      bus_if.dcache_wr_addr = 16'($urandom);
      bus_if.dcache_wr_data = 16'($urandom);
    end
    bus_if.dcache_wr_req   = wreq;
    bus_if.mem_data_valid  = dv;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    model_update();
    @(negedge clk);
    // Reset state: every output low.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step();

    // I-miss alone, valids on alternate cycles.
    idv_pulses = 0;
    for (int n = 0; n < 16; n++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, n[0]);
      step();
    end
    for (int n = 0; n < 3; n++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
    end
    check("s1_icache_pulses", 32'(idv_pulses), 32'd8);

    // Simultaneous misses after reset: D-cache first, then I-cache.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    #1;
    check("s2_dgrant_first", 32'(bus_if.dcache_grant), 32'd1);
    for (int n = 0; n < WPB; n++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      step();
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    #1;
    check("s2_igrant_second", 32'(bus_if.icache_grant), 32'd1);
    for (int n = 0; n < WPB; n++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      step();
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();

    // Write arrives during an I-fill and waits for IDLE, beating a fill request.
    ack_count = 0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    bus_if.dcache_wr_addr = 16'h0A12;
    bus_if.dcache_wr_data = 16'hBEEF;
    for (int n = 0; n < WPB; n++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      step();
    end
    check("s3_no_early_ack", 32'(ack_count), 32'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    check("s3_ack_count", 32'(ack_count), 32'd1);
    check("s3_ack_addr", 32'(ack_addr), 32'h0A12);
    check("s3_ack_data", 32'(ack_data), 32'hBEEF);

    // D-request withdrawn after 4 words: fill still runs to the 8th.
    ddv_pulses = 0;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    for (int n = 0; n < 4; n++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      step();
    end
    for (int n = 0; n < 7; n++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, n[0]);
      step();
    end
    #1;
    check("s4_dgrant_held", 32'(bus_if.dcache_grant), 32'd1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    #1;
    check("s4_dgrant_released", 32'(bus_if.dcache_grant), 32'd0);
    check("s4_dcache_pulses", 32'(ddv_pulses), 32'd8);

    // Reset mid-fill, then stray valids are ignored.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    for (int n = 0; n < 3; n++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      step();
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    idv_pulses = 0;
    ddv_pulses = 0;
    for (int n = 0; n < 5; n++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
    end
    check("s5_stray_icache", 32'(idv_pulses), 32'd0);
    check("s5_stray_dcache", 32'(ddv_pulses), 32'd0);
    // A fresh fill must still need all eight words.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    for (int n = 0; n < WPB; n++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      step();
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();

    // Random traffic.
    for (int n = 0; n < 4000; n++) begin
      drive($urandom_range(99) != 0,
            $urandom_range(2) == 0,
            $urandom_range(2) == 0,
            $urandom_range(5) == 0,
            $urandom_range(1) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_mem_arbiter
